rr_onehot_arbiter: RTL and testbench

//  Four-requester round-robin arbiter, directly upstream of the 4:2 encoder stage.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 33 +++
 rtl/rr_onehot_arbiter.sv | 104 ++++++++++
 tb/tb_rr_onehot_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin one-hot arbiter.
// Requester count, FSM states and the index-to-one-hot helper.
package arb_pkg;

  localparam int N_REQ = 4;

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  function automatic logic [N_REQ-1:0] onehot4(
    input logic [1:0] idx
  );
    logic [N_REQ-1:0] r;
    r = 4'b0001 << idx;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority picker: first set request at or after ptr.
// Rotate by ptr, fixed-priority pick, then rotate the index back.
module rr_pick
  import arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       any,
  output logic [1:0] pick_idx
);

  logic [3:0] rot;
  logic [1:0] fp;

  always_comb begin
    rot = '0;
    for (int i = 0; i < 4; i++) begin
      rot[i] = req[2'(i) + ptr];
    end
    fp = 2'd0;
    priority case (1'b1)
      rot[0]:  fp = 2'd0;
      rot[1]:  fp = 2'd1;
      rot[2]:  fp = 2'd2;
      rot[3]:  fp = 2'd3;
      default: fp = 2'd0;
    endcase
  end

  assign pick_idx = fp + ptr;
  assign any      = |req;

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Four-way round-robin arbiter with a registered one-hot grant,
// bounded hold time and a forced idle cycle between grants.
module rr_onehot_arbiter
  import arb_pkg::*;
#(
  parameter int N        = N_REQ,
  parameter int HOLD_MAX = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] gnt,
  output logic         gnt_valid,
  output logic         timeout
);

  localparam logic [7:0] HMAX = 8'(HOLD_MAX);

  state_e       state_q, state_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [1:0]   gidx_q, gidx_d;
  logic [7:0]   hold_q, hold_d;
  logic [N-1:0] gnt_q, gnt_d;
  logic         gv_q, gv_d;
  logic         to_q, to_d;

  logic         any;
  logic [1:0]   pick;
  logic         lim;
  logic         rel;

  rr_pick u_pick (
    .req      (req),
    .ptr      (ptr_q),
    .any      (any),
    .pick_idx (pick)
  );

  assign lim = (hold_q == HMAX);
  assign rel = done | ~req[gidx_q] | lim;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    gv_d    = gv_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          state_d = GRANT;
          gidx_d  = pick;
          gnt_d   = onehot4(pick);
          gv_d    = 1'b1;
          hold_d  = 8'd1;
        end
      end
      GRANT: begin
        if (rel) begin
          state_d = IDLE;
          gnt_d   = '0;
          gv_d    = 1'b0;
          ptr_d   = gidx_q + 2'd1;
          hold_d  = 8'd0;
          // timeout only when the limit alone forced the release
          to_d    = lim & ~done & req[gidx_q];
        end else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      gidx_q  <= 2'd0;
      hold_q  <= 8'd0;
      gnt_q   <= '0;
      gv_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      gv_q    <= gv_d;
      to_q    <= to_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gv_q;
  assign timeout   = to_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed and random checks of rr_onehot_arbiter against
// a cycle-level round-robin reference model.
module tb_rr_onehot_arbiter;

  localparam int HM = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  int nchk  = 0;
  int nfail = 0;

  // reference model state
  bit m_busy;
  int m_g;
  int m_ptr;
  int m_hold;
  bit m_to;

  rr_onehot_arbiter #(
    .N        (4),
    .HOLD_MAX (HM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] m_gnt();
    logic [3:0] v;
    v = 4'b0000;
    if (m_busy) v = 4'(1 << m_g);
    return v;
  endfunction

  task automatic mreset();
    m_busy = 0;
    m_g    = 0;
    m_ptr  = 0;
    m_hold = 0;
    m_to   = 0;
  endtask

  task automatic mstep();
    m_to = 0;
    if (!rst_n) begin
      mreset();
    end else if (!m_busy) begin
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (m_ptr + k) % 4;
        if (req[idx] && !m_busy) begin
          m_busy = 1;
          m_g    = idx;
          m_hold = 1;
        end
      end
    end else if (done || !req[m_g] || m_hold == HM) begin
      m_to   = (m_hold == HM) && !done && req[m_g];
      m_busy = 0;
      m_ptr  = (m_g + 1) % 4;
      m_hold = 0;
    end else if (m_hold < 255) begin
      m_hold++;
    end
  endtask

  task automatic ex4(string tag, logic [3:0] o, logic [3:0] e);
    nchk++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s: got %b want %b", tag, o, e);
    end
  endtask

  task automatic ex1(string tag, logic o, logic e);
    nchk++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s: got %b want %b", tag, o, e);
    end
  endtask

  task automatic chk(string tag);
    ex4({tag, ".gnt"}, gnt, m_gnt());
    ex1({tag, ".valid"}, gnt_valid, m_busy);
    ex1({tag, ".timeout"}, timeout, m_to);
    ex1({tag, ".onehot0"}, $onehot0(gnt), 1'b1);
    ex1({tag, ".vmatch"}, gnt_valid, |gnt);
  endtask

  task automatic tick(string tag);
    mstep();
    @(posedge clk);
    #1;
    chk(tag);
  endtask

  initial begin
    logic [3:0] rot_exp [9];
    mreset();

    // 1. reset with all requests pending
    req = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    chk("rst");
    ex4("rst.gnt0", gnt, 4'b0000);
    rst_n = 1'b1;
    tick("rst_rel");
    ex4("rst_rel.first", gnt, 4'b0001);

    // 2. rotation with done held high
    rot_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000,
                4'b0100, 4'b0000, 4'b1000, 4'b0000,
                4'b0001};
    done = 1'b1;
    for (int i = 1; i < 9; i++) begin
      tick("rot");
      ex4("rot.seq", gnt, rot_exp[i]);
    end

    // 3. sparse requests from ptr=1
    tick("sp_rel");
    req  = 4'b1001;
    done = 1'b0;
    tick("sp_a");
    ex4("sp.g3", gnt, 4'b1000);
    done = 1'b1;
    tick("sp_done");
    req  = 4'b0001;
    done = 1'b0;
    tick("sp_b");
    ex4("sp.g0", gnt, 4'b0001);
    done = 1'b1;
    tick("sp_end");

    // 4. hold to the limit
    req  = 4'b0100;
    done = 1'b0;
    for (int i = 0; i < HM; i++) begin
      tick("to_hold");
      ex4("to.held", gnt, 4'b0100);
      ex1("to.nopulse", timeout, 1'b0);
    end
    tick("to_rel");
    ex4("to.idle", gnt, 4'b0000);
    ex1("to.pulse", timeout, 1'b1);
    tick("to_regrant");
    ex4("to.regrant", gnt, 4'b0100);
    ex1("to.pulse_end", timeout, 1'b0);

    // 5. done and request drop at the limit
    for (int i = 1; i < HM; i++) tick("sim_hold");
    done = 1'b1;
    req  = 4'b0000;
    tick("sim_rel");
    ex4("sim.idle", gnt, 4'b0000);
    ex1("sim.no_to", timeout, 1'b0);
    done = 1'b0;
    req  = 4'b1111;
    tick("sim_ptr");
    ex4("sim.ptr3", gnt, 4'b1000);

    // 6. async reset mid-grant
    done = 1'b1;
    tick("ar_rel");
    done = 1'b0;
    req  = 4'b0010;
    tick("ar_g");
    ex4("ar.g1", gnt, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    mreset();
    chk("ar_async");
    req = 4'b1111;
    tick("ar_hold");
    rst_n = 1'b1;
    tick("ar_after");
    ex4("ar.ptr0", gnt, 4'b0001);

    // random traffic with occasional async resets
    for (int i = 0; i < 600; i++) begin
      req  = 4'($urandom_range(15));
      done = ($urandom_range(3) == 0);
      if ($urandom_range(63) == 0) begin
        rst_n = 1'b0;
        #1;
        mreset();
        chk("rnd_rst");
        rst_n = 1'b1;
      end
      tick("rnd");
    end

    // random with sticky requests to exercise the limit
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(7) == 0) req = 4'($urandom_range(15));
      done = ($urandom_range(15) == 0);
      tick("rnd_sticky");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
